// File: rtl/store_drain_buffer.sv
// store_drain_buffer: posted-write buffer between the core store path and the
// memory write port. Stores are queued in a DEPTH-entry circular buffer and
// drained in order, one at a time, over a req/ack handshake. The head entry is
// registered onto o_mem_* and held stable until acknowledged.
// Optional feature macro: STORE_FWD_EN (store-to-load forwarding lookup).
module store_drain_buffer #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_areset,
  input  logic                       i_st_valid,
  input  logic [AW-1:0]              i_st_addr,
  input  logic [DW-1:0]              i_st_data,
  input  logic [DW/8-1:0]            i_st_be,
  output logic                       o_st_ready,
  output logic                       o_mem_req,
  output logic [AW-1:0]              o_mem_addr,
  output logic [DW-1:0]              o_mem_data,
  output logic [DW/8-1:0]            o_mem_be,
  input  logic                       i_mem_ack,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  input  logic [AW-1:0]              i_ld_addr,
  output logic                       o_fwd_hit,
  output logic [DW-1:0]              o_fwd_data,
  output logic [DW/8-1:0]            o_fwd_be
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DW / 8;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Control state (reset)
  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mem_req_q, mem_req_d;

  // Head presentation registers (data, not reset)
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;

  // Entry storage (not cleared by reset)
  logic [AW-1:0]   entry_addr_q [DEPTH];
  logic [DW-1:0]   entry_data_q [DEPTH];
  logic [BW-1:0]   entry_be_q   [DEPTH];

  logic            full;
  logic            push;
  logic            pop;
  logic            load_head;
  logic [CW-1:0]   remain;

  assign full = (count_q == CW'(DEPTH));

  // Next-state logic: push/pop bookkeeping, drain FSM and next head selection
  always_comb begin
    push      = i_st_valid && !full;
    pop       = (state_q == S_REQ) && i_mem_ack;
    wr_ptr_d  = wr_ptr_q + PW'(push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    // Entries already stored that survive this cycle's pop; when none do, the
    // next head can only be the store arriving this cycle.
    remain    = count_q - CW'(pop);
    state_d   = (count_d != '0) ? S_REQ : S_IDLE;
    mem_req_d = (count_d != '0);
    // Head outputs only change when leaving IDLE or after an ack, so they stay
    // stable for the whole duration of a request.
    load_head = (state_q == S_IDLE) || pop;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_be_d   = mem_be_q;
    if (load_head) begin
      if (remain == '0) begin
        mem_addr_d = i_st_addr;
        mem_data_d = i_st_data;
        mem_be_d   = i_st_be;
      end else begin
        mem_addr_d = entry_addr_q[rd_ptr_d];
        mem_data_d = entry_data_q[rd_ptr_d];
        mem_be_d   = entry_be_q[rd_ptr_d];
      end
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Head presentation registers
  always_ff @(posedge i_clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
    mem_be_q   <= mem_be_d;
  end

  // Entry storage write at the write pointer
  always_ff @(posedge i_clk) begin
    if (push) begin
      entry_addr_q[wr_ptr_q] <= i_st_addr;
      entry_data_q[wr_ptr_q] <= i_st_data;
      entry_be_q[wr_ptr_q]   <= i_st_be;
    end
  end

  assign o_st_ready = !full;
  assign o_full     = full;
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;
  assign o_mem_req  = mem_req_q;
  assign o_mem_addr = mem_addr_q;
  assign o_mem_data = mem_data_q;
  assign o_mem_be   = mem_be_q;

`ifdef STORE_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Forwarding lookup: scan oldest to youngest so the youngest match wins
  always_comb begin
    o_fwd_hit  = 1'b0;
    o_fwd_data = '0;
    o_fwd_be   = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (entry_addr_q[fwd_idx] == i_ld_addr)) begin
        o_fwd_hit  = 1'b1;
        o_fwd_data = entry_data_q[fwd_idx];
        o_fwd_be   = entry_be_q[fwd_idx];
      end
    end
  end
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^i_ld_addr;
  assign o_fwd_hit  = 1'b0;
  assign o_fwd_data = '0;
  assign o_fwd_be   = '0;
`endif

endmodule
